// File: rtl/hpdcache_id_release_pkg.sv
// rtl/hpdcache_id_release_pkg.sv - local types for the ID release block
package hpdcache_id_release_pkg;

    localparam int REL_SRC_COUNT = 2;

    typedef enum logic {
        REL_SRC_A = 1'b0,
        REL_SRC_B = 1'b1
    } rel_src_e;

endpackage

// File: rtl/hpdcache_rrarb.sv
// rtl/hpdcache_rrarb.sv - N-way round-robin arbiter, pointer advances on accepted grant
module hpdcache_rrarb #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         ready_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    logic          w_found;

    // First requester at or after the pointer wins; remember the slot after it
    always_comb begin
        gnt_o   = '0;
        w_next  = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            automatic int idx = (int'(r_ptr) + i) % N;
            if (!w_found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                w_next     = PW'((idx + 1) % N);
                w_found    = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when the grant is consumed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (ready_i && w_found) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/hpdcache_id_release.sv
// rtl/hpdcache_id_release.sv - in-use bitmap and release merge in front of the ID free-list
module hpdcache_id_release
    import hpdcache_id_release_pkg::*;
#(
    parameter int unsigned ID_COUNT = 8,
    parameter int unsigned ID_WIDTH = $clog2(ID_COUNT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                alloc_i,
    input  logic [ID_WIDTH-1:0] alloc_id_i,
    input  logic                rel_a_valid_i,
    output logic                rel_a_ready_o,
    input  logic [ID_WIDTH-1:0] rel_a_id_i,
    input  logic                rel_b_valid_i,
    output logic                rel_b_ready_o,
    input  logic [ID_WIDTH-1:0] rel_b_id_i,
    output logic                fl_w_o,
    input  logic                fl_wok_i,
    output logic [ID_WIDTH-1:0] fl_wdata_o,
    output logic [ID_COUNT-1:0] inuse_o,
    output logic                idle_o,
    output logic                err_double_alloc_o,
    output logic                err_double_free_o
);

    logic [ID_COUNT-1:0]      r_inuse;
    logic                     r_out_valid;
    logic [ID_WIDTH-1:0]      r_out_id;
    logic                     r_err_alloc;
    logic                     r_err_free;

    logic                     w_accept;
    logic [REL_SRC_COUNT-1:0] w_gnt;
    rel_src_e                 w_src;
    logic                     w_rel_fire;
    logic [ID_WIDTH-1:0]      w_rel_id;
    logic                     w_rel_known;
    logic [ID_COUNT-1:0]      w_inuse_next;

    // A release can land when the slot is empty or is being pushed right now
    assign w_accept = ~rst_i & (~r_out_valid | fl_wok_i);

    hpdcache_rrarb #(
        .N (REL_SRC_COUNT)
    ) u_rrarb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   ({rel_b_valid_i, rel_a_valid_i}),
        .ready_i (w_accept),
        .gnt_o   (w_gnt)
    );

    assign rel_a_ready_o = w_accept & w_gnt[0];
    assign rel_b_ready_o = w_accept & w_gnt[1];
    assign w_src         = w_gnt[1] ? REL_SRC_B : REL_SRC_A;
    assign w_rel_id      = (w_src == REL_SRC_B) ? rel_b_id_i : rel_a_id_i;
    assign w_rel_fire    = (rel_a_valid_i & rel_a_ready_o) | (rel_b_valid_i & rel_b_ready_o);
    assign w_rel_known   = r_inuse[w_rel_id];

    // Release clears, alloc sets; both look at the current bitmap and set wins
    always_comb begin
        w_inuse_next = r_inuse;
        if (w_rel_fire && w_rel_known) begin
            w_inuse_next[w_rel_id] = 1'b0;
        end
        if (alloc_i) begin
            w_inuse_next[alloc_id_i] = 1'b1;
        end
    end

    // Bitmap, output slot and error pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inuse     <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
            r_err_alloc <= 1'b0;
            r_err_free  <= 1'b0;
        end else begin
            r_inuse     <= w_inuse_next;
            r_err_alloc <= alloc_i & r_inuse[alloc_id_i];
            r_err_free  <= w_rel_fire & ~w_rel_known;
            if (w_rel_fire && w_rel_known) begin
                r_out_valid <= 1'b1;
                r_out_id    <= w_rel_id;
            end else if (r_out_valid && fl_wok_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign fl_w_o             = r_out_valid & ~rst_i;
    assign fl_wdata_o         = r_out_id;
    assign inuse_o            = r_inuse;
    assign idle_o             = ~(|r_inuse) & ~r_out_valid;
    assign err_double_alloc_o = r_err_alloc;
    assign err_double_free_o  = r_err_free;

`ifndef HPDCACHE_ASSERT_OFF
    a_wdata_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (fl_w_o && !fl_wok_i) |=> $stable(fl_wdata_o));
    a_one_ready : assert property (@(posedge clk_i) disable iff (rst_i)
        !(rel_a_ready_o && rel_b_ready_o));
`endif

endmodule

// File: tb/tb_hpdcache_id_release.sv
// tb/tb_hpdcache_id_release.sv - scoreboard bench for hpdcache_id_release
module tb_hpdcache_id_release;

    localparam int N = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       alloc_i = 1'b0;
    logic [2:0] alloc_id_i = '0;
    logic       rel_a_valid_i = 1'b0;
    logic       rel_a_ready_o;
    logic [2:0] rel_a_id_i = '0;
    logic       rel_b_valid_i = 1'b0;
    logic       rel_b_ready_o;
    logic [2:0] rel_b_id_i = '0;
    logic       fl_w_o;
    logic       fl_wok_i = 1'b0;
    logic [2:0] fl_wdata_o;
    logic [7:0] inuse_o;
    logic       idle_o;
    logic       err_double_alloc_o;
    logic       err_double_free_o;

    hpdcache_id_release dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .alloc_i            (alloc_i),
        .alloc_id_i         (alloc_id_i),
        .rel_a_valid_i      (rel_a_valid_i),
        .rel_a_ready_o      (rel_a_ready_o),
        .rel_a_id_i         (rel_a_id_i),
        .rel_b_valid_i      (rel_b_valid_i),
        .rel_b_ready_o      (rel_b_ready_o),
        .rel_b_id_i         (rel_b_id_i),
        .fl_w_o             (fl_w_o),
        .fl_wok_i           (fl_wok_i),
        .fl_wdata_o         (fl_wdata_o),
        .inuse_o            (inuse_o),
        .idle_o             (idle_o),
        .err_double_alloc_o (err_double_alloc_o),
        .err_double_free_o  (err_double_free_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // reference state: set of live IDs, one pending push, who goes first on a tie
    bit [N-1:0] m_inuse = '0;
    bit         m_pend = 1'b0;
    int         m_pend_id = 0;
    bit         m_prefer_b = 1'b0;
    bit         m_eda = 1'b0;
    bit         m_edf = 1'b0;
    int         exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: every completed push must match the oldest expected ID
    always @(negedge clk_i) begin
        #2;
        if (!rst_i && fl_w_o && fl_wok_i) begin
            if (exp_q.size() == 0) begin
                chk("push_unexpected", {29'd0, fl_wdata_o}, 32'hFFFF_FFFF);
            end else begin
                chk("push_id", {29'd0, fl_wdata_o}, exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit al, input int aid, input bit va, input int ida,
                        input bit vb, input int idb, input bit wok);
        bit acc, ga, gb, fire, known;
        int rid;
        @(negedge clk_i);
        alloc_i       = al;
        alloc_id_i    = 3'(aid);
        rel_a_valid_i = va;
        rel_a_id_i    = 3'(ida);
        rel_b_valid_i = vb;
        rel_b_id_i    = 3'(idb);
        fl_wok_i      = wok;
        #1;
        acc = !m_pend || wok;
        ga  = acc && va && (!vb || !m_prefer_b);
        gb  = acc && vb && (!va || m_prefer_b);
        chk("inuse", {24'd0, inuse_o}, {24'd0, m_inuse});
        chk("idle", {31'd0, idle_o}, {31'd0, (m_inuse == 0) && !m_pend});
        chk("fl_w", {31'd0, fl_w_o}, {31'd0, m_pend});
        chk("err_alloc", {31'd0, err_double_alloc_o}, {31'd0, m_eda});
        chk("err_free", {31'd0, err_double_free_o}, {31'd0, m_edf});
        chk("ready_a", {31'd0, rel_a_ready_o}, {31'd0, ga});
        chk("ready_b", {31'd0, rel_b_ready_o}, {31'd0, gb});
        if (m_pend) chk("pend_id", {29'd0, fl_wdata_o}, m_pend_id);
        fire  = ga || gb;
        rid   = ga ? ida : idb;
        known = fire && m_inuse[rid];
        m_eda = al && m_inuse[aid];
        m_edf = fire && !known;
        if (fire) m_prefer_b = ga;
        if (known) m_inuse[rid] = 1'b0;
        if (al) m_inuse[aid] = 1'b1;
        if (known) begin
            m_pend    = 1'b1;
            m_pend_id = rid;
            exp_q.push_back(rid);
        end else if (m_pend && wok) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i         = 1'b1;
        alloc_i       = 1'b0;
        rel_a_valid_i = 1'b1;
        rel_b_valid_i = 1'b1;
        fl_wok_i      = 1'b1;
        #1;
        chk("rst_ready_a", {31'd0, rel_a_ready_o}, 32'd0);
        chk("rst_ready_b", {31'd0, rel_b_ready_o}, 32'd0);
        chk("rst_fl_w", {31'd0, fl_w_o}, 32'd0);
        @(negedge clk_i);
        rst_i         = 1'b0;
        rel_a_valid_i = 1'b0;
        rel_b_valid_i = 1'b0;
        m_inuse    = '0;
        m_pend     = 1'b0;
        m_prefer_b = 1'b0;
        m_eda      = 1'b0;
        m_edf      = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        // fill the bitmap
        for (int i = 0; i < N; i++) step(1, i, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // simultaneous releases: A first, B follows
        step(0, 0, 1, 3, 1, 5, 1);
        step(0, 0, 0, 0, 1, 5, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // back-pressure with ID 2 pending
        step(0, 0, 1, 2, 0, 0, 0);
        repeat (4) step(0, 0, 1, 7, 0, 0, 0);
        step(0, 0, 1, 7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // double free of 6
        step(0, 0, 1, 6, 0, 0, 1);
        step(0, 0, 1, 6, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // alloc and release of live ID 4 together
        step(1, 4, 1, 4, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, N - 1),
                 $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                 $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                 $urandom_range(0, 3) != 0);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        // reset with ID 1 pending and 0..3 live
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hpdcache_id_release.md
HPDCACHE_ID_RELEASE -- requirements
Module: hpdcache_id_release

Interface
REQ-001 SHALL have parameter ID_COUNT, default 8: number of IDs managed by the companion free-list FIFO (power of two, >=2).
REQ-002 SHALL have parameter ID_WIDTH, default $clog2(ID_COUNT): width of every ID port.
REQ-003 SHALL provide the following ports, with one clock and a synchronous, active-high reset:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous active-high reset.
- alloc_i  in  1  free-list pop strobe (free-list r_i AND rok_o).
- alloc_id_i  in  ID_WIDTH  ID popped.
- rel_a_valid_i / rel_a_ready_o / rel_a_id_i  in / out / in  1 / 1 / ID_WIDTH  release source A.
- rel_b_valid_i / rel_b_ready_o / rel_b_id_i  in / out / in  1 / 1 / ID_WIDTH  release source B.
- fl_w_o  out  1  push request to free-list w_i.
- fl_wok_i  in  1  free-list wok_o.
- fl_wdata_o  out  ID_WIDTH  ID pushed.
- inuse_o  out  ID_COUNT  bit i = ID i allocated and not yet released.
- idle_o  out  1  all IDs free and nothing pending.
- err_double_alloc_o  out  1  one-cycle error pulse.
- err_double_free_o  out  1  one-cycle error pulse.

Function
REQ-004 SHALL hold one output register (valid bit + ID); fl_w_o = valid bit, fl_wdata_o = stored ID.
REQ-005 Output register SHALL drain in the cycle where fl_w_o and fl_wok_i are both 1; it clears next edge unless it is refilled in the same cycle.
REQ-006 A release SHALL be acceptable when the output register is empty or drains in the current cycle; the register refills with zero bubble, so sustained throughput is 1 ID/cycle.
REQ-007 When both sources are valid and a release is acceptable, SHALL grant exactly one by 2-way round-robin; the grant pointer moves past the granted source only on acceptance.
REQ-008 When only one source is valid, SHALL grant it regardless of the round-robin pointer.
REQ-009 rel_x_ready_o SHALL be 1 only for the granted source, and SHALL depend combinationally on rel_x_valid_i and fl_wok_i only; it never depends on the ID value.
REQ-010 Accepted release of an ID with inuse_q[id]=1: SHALL clear that bit at the next edge and load the ID into the output register. fl_w_o SHALL be visible 1 cycle after acceptance.
REQ-011 Accepted release of an ID with inuse_q[id]=0: SHALL consume the handshake, drop the ID (output register not loaded), and pulse err_double_free_o the next cycle.
REQ-012 alloc_i=1 with inuse_q[alloc_id_i]=0: SHALL set the bit at the next edge.
REQ-013 alloc_i=1 with inuse_q[alloc_id_i]=1: SHALL pulse err_double_alloc_o the next cycle; the bit stays 1.
REQ-014 Alloc and release in the same cycle SHALL both be evaluated against inuse_q. If they target the same ID, set wins (bit = 1).
REQ-015 fl_wdata_o SHALL hold stable while fl_w_o=1 and fl_wok_i=0.
REQ-016 idle_o = (inuse_q == 0) AND output register empty; registered-state only.
REQ-017 inuse_o = inuse_q, with no combinational bypass.

Reset
REQ-018 rst_i=1 at a clock edge SHALL set:
- inuse_q = 0 (matches the free-list initialised full)
- output register invalid
- round-robin pointer = A
- both error outputs 0
REQ-019 During reset, rel_a_ready_o, rel_b_ready_o and fl_w_o SHALL be 0.
REQ-020 A pending ID in the output register at reset SHALL be discarded; the free-list is reset concurrently.

Structure
REQ-021 No shared-package additions are required; ID_WIDTH derives locally. An ID typedef SHALL be placed in the hpdcache package only if other blocks reuse it.
REQ-022 The 2-way arbitration SHALL instantiate the existing hpdcache_rrarb sub-module; bitmap and output register stay in this module.
REQ-023 Assertions (disabled by HPDCACHE_ASSERT_OFF) SHALL check:
- fl_wdata_o stable while fl_w_o AND NOT fl_wok_i
- never both readies asserted

Verification
REQ-024 Reset, then alloc IDs 0..7 on consecutive cycles -> inuse_o=8'hFF, idle_o=0, no errors.
REQ-025 A releases 3 and B releases 5 in the same cycle, fl_wok_i=1 -> A granted first, B next cycle; fl_wdata_o=3 then 5; inuse_o bits 3,5 cleared.
REQ-026 fl_wok_i=0 for 4 cycles with ID 2 pending -> fl_w_o=1, fl_wdata_o=2 stable, both readies 0; fl_wok_i=1 -> push, new release accepted same cycle.
REQ-027 Release ID 6 while inuse_o[6]=0 -> handshake completes, err_double_free_o pulses 1 cycle, fl_w_o stays 0.
REQ-028 Alloc 4 and A releases 4 in the same cycle with inuse_q[4]=1 -> ID 4 pushed, err_double_alloc_o pulses, inuse_o[4]=1.
REQ-029 Assert rst_i with ID 1 pending and inuse_o=8'h0F -> next cycle fl_w_o=0, inuse_o=0, idle_o=1.
